// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frogger_pkg
//  Description : Shared types and screen constants for the frog controller
//                and its sub-blocks: facing encoding, controller state
//                encoding, and playfield geometry defaults.
//  Revision    : 1.0  initial release
// ============================================================================
package frogger_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FROG_SIZE = 32;

    typedef enum logic [1:0] {
        FACE_UP    = 2'b00,
        FACE_DOWN  = 2'b01,
        FACE_LEFT  = 2'b10,
        FACE_RIGHT = 2'b11
    } face_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOP  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frog_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_edge
//  Description : Registers the four debounced direction buttons and reports a
//                press on any rising edge. Simultaneous presses resolve by
//                priority up > down > left > right.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_btn[3:0]    - {up, down, left, right} levels
//                o_press       - a rising edge was seen this clk
//                o_dir         - direction of the highest-priority edge
//  Revision    : 1.0  initial release
// ============================================================================
module btn_edge
    import frogger_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_btn,
    output logic       o_press,
    output face_t      o_dir
);

    logic [3:0] r_prev;
    logic [3:0] w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 4'b0000;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign w_rise = i_btn & ~r_prev;

    always_comb begin
        o_press = |w_rise;
        o_dir   = FACE_UP;
        if (w_rise[3]) begin
            o_dir = FACE_UP;
        end else if (w_rise[2]) begin
            o_dir = FACE_DOWN;
        end else if (w_rise[1]) begin
            o_dir = FACE_LEFT;
        end else if (w_rise[0]) begin
            o_dir = FACE_RIGHT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frog_ctrl
//  Description : Per-frame movement controller for the player frog. Button
//                presses become multi-frame hops of STEP pixels; a collision
//                hit starts a death/respawn sequence. Position only changes on
//                frame_tick so the renderer never sees a torn position.
//  Ports       : clk, rst            - clock, asynchronous active-high reset
//                frame_tick          - one-clk pulse per frame
//                btn_up/down/left/right - debounced button levels
//                hit                 - collision level, sampled on frame_tick
//                frog_x, frog_y      - sprite top-left corner
//                facing              - 00 up, 01 down, 10 left, 11 right
//                hopping, dead       - state indicators
//                hop_done, fwd_done  - one-clk pulses at hop completion
//  Options     : FROG_HOP_QUEUE_EN - when defined, a press during a hop is
//                held and evaluated after the hop returns to idle.
//  Revision    : 1.0  initial release
// ============================================================================
module frog_ctrl #(
    parameter int SCREEN_W     = frogger_pkg::SCREEN_W,
    parameter int SCREEN_H     = frogger_pkg::SCREEN_H,
    parameter int FROG_SIZE    = frogger_pkg::FROG_SIZE,
    parameter int STEP         = 32,
    parameter int HOP_FRAMES   = 4,
    parameter int START_X      = 304,
    parameter int START_Y      = 448,
    parameter int DEATH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       hit,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic [1:0] facing,
    output logic       hopping,
    output logic       dead,
    output logic       hop_done,
    output logic       fwd_done
);

    import frogger_pkg::*;

    localparam int c_HOP_W   = (HOP_FRAMES   > 1) ? $clog2(HOP_FRAMES)   : 1;
    localparam int c_DEATH_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    localparam logic [9:0]           c_STEP_PX    = 10'(STEP / HOP_FRAMES);
    localparam logic [9:0]           c_START_X    = 10'(START_X);
    localparam logic [9:0]           c_START_Y    = 10'(START_Y);
    localparam logic [c_HOP_W-1:0]   c_HOP_ONE    = c_HOP_W'(1);
    localparam logic [c_HOP_W-1:0]   c_HOP_LAST   = c_HOP_W'(HOP_FRAMES - 1);
    localparam logic [c_DEATH_W-1:0] c_DEATH_ONE  = c_DEATH_W'(1);
    localparam logic [c_DEATH_W-1:0] c_DEATH_LAST = c_DEATH_W'(DEATH_FRAMES - 1);

    state_t               r_state;
    logic                 r_pend_vld;
    face_t                r_pend_dir;
    face_t                r_face;
    logic [9:0]           r_x;
    logic [9:0]           r_y;
    logic [c_HOP_W-1:0]   r_hop_cnt;
    logic [c_DEATH_W-1:0] r_death_cnt;
    logic                 r_hopping;
    logic                 r_dead;
    logic                 r_hop_done;
    logic                 r_fwd_done;

    logic                 w_press;
    face_t                w_dir;
    logic                 w_pend_wr;

    btn_edge u_btn_edge (
        .clk     (clk),
        .rst     (rst),
        .i_btn   ({btn_up, btn_down, btn_left, btn_right}),
        .o_press (w_press),
        .o_dir   (w_dir)
    );

    // The whole STEP target is checked up front; the per-frame partial steps
    // then stay inside the same range and cannot wrap.
    function automatic logic target_ok(input face_t d, input logic [9:0] x,
                                       input logic [9:0] y);
        logic ok;
        ok = 1'b0;
        case (d)
            FACE_UP:    ok = (int'(y) >= STEP);
            FACE_DOWN:  ok = (int'(y) + STEP <= SCREEN_H - FROG_SIZE);
            FACE_LEFT:  ok = (int'(x) >= STEP);
            FACE_RIGHT: ok = (int'(x) + STEP <= SCREEN_W - FROG_SIZE);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [9:0] step_x(input face_t d, input logic [9:0] x);
        logic [9:0] nx;
        nx = x;
        if (d == FACE_LEFT) begin
            nx = x - c_STEP_PX;
        end else if (d == FACE_RIGHT) begin
            nx = x + c_STEP_PX;
        end
        return nx;
    endfunction

    function automatic logic [9:0] step_y(input face_t d, input logic [9:0] y);
        logic [9:0] ny;
        ny = y;
        if (d == FACE_UP) begin
            ny = y - c_STEP_PX;
        end else if (d == FACE_DOWN) begin
            ny = y + c_STEP_PX;
        end
        return ny;
    endfunction

`ifdef FROG_HOP_QUEUE_EN
    assign w_pend_wr = w_press && ((r_state == ST_IDLE) || (r_state == ST_HOP));
`else
    assign w_pend_wr = w_press && (r_state == ST_IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pend_vld  <= 1'b0;
            r_pend_dir  <= FACE_UP;
            r_face      <= FACE_UP;
            r_x         <= c_START_X;
            r_y         <= c_START_Y;
            r_hop_cnt   <= '0;
            r_death_cnt <= '0;
            r_hopping   <= 1'b0;
            r_dead      <= 1'b0;
            r_hop_done  <= 1'b0;
            r_fwd_done  <= 1'b0;
        end else begin
            r_hop_done <= 1'b0;
            r_fwd_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        if (hit) begin
                            r_state     <= ST_DEAD;
                            r_dead      <= 1'b1;
                            r_death_cnt <= '0;
                        end else if (r_pend_vld) begin
                            // A rejected hop still turns the frog.
                            r_face     <= r_pend_dir;
                            r_pend_vld <= 1'b0;
                            if (target_ok(r_pend_dir, r_x, r_y)) begin
                                r_x <= step_x(r_pend_dir, r_x);
                                r_y <= step_y(r_pend_dir, r_y);
                                if (HOP_FRAMES == 1) begin
                                    r_hop_done <= 1'b1;
                                    r_fwd_done <= (r_pend_dir == FACE_UP);
                                end else begin
                                    r_state   <= ST_HOP;
                                    r_hopping <= 1'b1;
                                    r_hop_cnt <= c_HOP_ONE;
                                end
                            end
                        end
                    end
                end

                ST_HOP: begin
                    if (frame_tick) begin
                        if (hit) begin
                            // Freeze at the partial position; no completion pulse.
                            r_state     <= ST_DEAD;
                            r_hopping   <= 1'b0;
                            r_dead      <= 1'b1;
                            r_death_cnt <= '0;
                        end else begin
                            r_x <= step_x(r_face, r_x);
                            r_y <= step_y(r_face, r_y);
                            if (r_hop_cnt == c_HOP_LAST) begin
                                r_state    <= ST_IDLE;
                                r_hopping  <= 1'b0;
                                r_hop_done <= 1'b1;
                                r_fwd_done <= (r_face == FACE_UP);
                            end else begin
                                r_hop_cnt <= r_hop_cnt + c_HOP_ONE;
                            end
                        end
                    end
                end

                ST_DEAD: begin
                    if (frame_tick) begin
                        if (r_death_cnt == c_DEATH_LAST) begin
                            r_state    <= ST_IDLE;
                            r_dead     <= 1'b0;
                            r_x        <= c_START_X;
                            r_y        <= c_START_Y;
                            r_face     <= FACE_UP;
                            r_pend_vld <= 1'b0;
                        end else begin
                            r_death_cnt <= r_death_cnt + c_DEATH_ONE;
                        end
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_hopping <= 1'b0;
                    r_dead    <= 1'b0;
                end
            endcase

            // A press on the same clk as a tick is kept for the next tick.
            if (w_pend_wr) begin
                r_pend_vld <= 1'b1;
                r_pend_dir <= w_dir;
            end
        end
    end

    assign frog_x   = r_x;
    assign frog_y   = r_y;
    assign facing   = r_face;
    assign hopping  = r_hopping;
    assign dead     = r_dead;
    assign hop_done = r_hop_done;
    assign fwd_done = r_fwd_done;

endmodule
`default_nettype wire

// File: tb/tb_frog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frog_ctrl
//  Description : Self-checking bench for frog_ctrl. Each frame tick pushes a
//                hand-computed expected snapshot; a monitor pops and compares
//                it on the falling edge after the tick is taken.
//  Options     : FROG_HOP_QUEUE_EN selects the queued-press expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frog_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic [1:0] facing;
    logic       hopping;
    logic       dead;
    logic       hop_done;
    logic       fwd_done;

    frog_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .hit        (hit),
        .frog_x     (frog_x),
        .frog_y     (frog_y),
        .facing     (facing),
        .hopping    (hopping),
        .dead       (dead),
        .hop_done   (hop_done),
        .fwd_done   (fwd_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int x;
        int y;
        int f;
        int hop;
        int dd;
        int hd;
        int fd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_ticks  = 0;
    logic tick_seen = 1'b0;

    task automatic check1(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) tick_seen <= frame_tick;

    // Monitor: the DUT presents a new snapshot after every taken frame tick.
    always @(negedge clk) begin
        if (!rst) begin
            if (tick_seen) begin
                if (sb_q.size() == 0) begin
                    check1("scoreboard_underflow", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check1($sformatf("tick%0d.x", mon_e.id), int'(frog_x), mon_e.x);
                    check1($sformatf("tick%0d.y", mon_e.id), int'(frog_y), mon_e.y);
                    check1($sformatf("tick%0d.facing", mon_e.id), int'(facing), mon_e.f);
                    check1($sformatf("tick%0d.hopping", mon_e.id), int'(hopping), mon_e.hop);
                    check1($sformatf("tick%0d.dead", mon_e.id), int'(dead), mon_e.dd);
                    check1($sformatf("tick%0d.hop_done", mon_e.id), int'(hop_done), mon_e.hd);
                    check1($sformatf("tick%0d.fwd_done", mon_e.id), int'(fwd_done), mon_e.fd);
                end
            end else begin
                // Completion pulses must be exactly one clk wide.
                check1("idle_cycle.pulses", int'({hop_done, fwd_done}), 0);
            end
        end
    end

    task automatic tick(input logic h, input int x, input int y, input int f,
                        input int hop, input int dd, input int hd, input int fd);
        exp_t e;
        @(negedge clk);
        n_ticks++;
        e.id = n_ticks; e.x = x; e.y = y; e.f = f;
        e.hop = hop; e.dd = dd; e.hd = hd; e.fd = fd;
        sb_q.push_back(e);
        hit = h;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        hit = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        repeat (2) @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check1("reset.x", int'(frog_x), 304);
        check1("reset.y", int'(frog_y), 448);
        check1("reset.facing", int'(facing), 0);
        check1("reset.flags", int'({hopping, dead, hop_done, fwd_done}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        int bx;
        int bf;

        do_reset();

        // Idle frames: nothing moves.
        for (int i = 0; i < 10; i++) tick(1'b0, 304, 448, 0, 0, 0, 0, 0);

        // Forward hop: four 8-pixel steps, pulses on completion.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 304, 440, 0, 1, 0, 0, 0);
        tick(1'b0, 304, 432, 0, 1, 0, 0, 0);
        tick(1'b0, 304, 424, 0, 1, 0, 0, 0);
        tick(1'b0, 304, 416, 0, 0, 0, 1, 1);
        tick(1'b0, 304, 416, 0, 0, 0, 0, 0);

        // Down at the bottom edge: turns only.
        do_reset();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 304, 448, 1, 0, 0, 0, 0);
        tick(1'b0, 304, 448, 1, 0, 0, 0, 0);

        // Left hop killed on its second tick, then the full death sequence.
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 296, 448, 2, 1, 0, 0, 0);
        tick(1'b1, 296, 448, 2, 0, 1, 0, 0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 60; i++) tick((i < 5), 296, 448, 2, 0, 1, 0, 0);
        tick(1'b0, 304, 448, 0, 0, 0, 0, 0);
        tick(1'b0, 304, 448, 0, 0, 0, 0, 0);

        // Simultaneous up+right takes up; left arrives mid-hop.
        press(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 304, 440, 0, 1, 0, 0, 0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 304, 432, 0, 1, 0, 0, 0);
        tick(1'b0, 304, 424, 0, 1, 0, 0, 0);
        tick(1'b0, 304, 416, 0, 0, 0, 1, 1);
`ifdef FROG_HOP_QUEUE_EN
        tick(1'b0, 296, 416, 2, 1, 0, 0, 0);
        tick(1'b0, 288, 416, 2, 1, 0, 0, 0);
        tick(1'b0, 280, 416, 2, 1, 0, 0, 0);
        tick(1'b0, 272, 416, 2, 0, 0, 1, 0);
        bx = 272;
        bf = 2;
`else
        tick(1'b0, 304, 416, 0, 0, 0, 0, 0);
        tick(1'b0, 304, 416, 0, 0, 0, 0, 0);
        bx = 304;
        bf = 0;
`endif

        // Hit and a pending press on the same idle tick: death wins.
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, bx, 416, bf, 0, 1, 0, 0);
        tick(1'b0, bx, 416, bf, 0, 1, 0, 0);

        // Reset in the middle of death restores everything at once.
        do_reset();
        tick(1'b0, 304, 448, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check1("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
